decoder_nx2n_scan: RTL and testbench
====================================

// Module: decoder_nx2n_scan
// PURPOSE
//  Parametrised N-to-2^N one-hot decoder with a registered output and two modes.
//  - Direct mode: holds a loaded code as a one-hot output.
//  - Scan mode: walks the one-hot output through every line, with a programmable
//    dwell time per line.
//  Used as a select/strobe generator for banked peripherals and for scanning
//  display/LED rows. Supersedes the fixed combinational 3x8 decoder.
// PARAMETERS
//  N_IN     3   input code width; output width is 2**N_IN
//  DWELL_W  4   width of the dwell (cycles-per-line) field
// PORTS
//  clk       input   1            rising-edge clock
//  rst       input   1            asynchronous, active-high reset
//  en        input   1            block enable; 0 forces outputs inactive
//  load      input   1            single-cycle command strobe; samples mode/data_in/dwell
//  mode      input   1            0 = direct, 1 = scan (sampled only on load)
//  data_in   input   N_IN         code to decode (direct) or start index (scan)
//  dwell     input   DWELL_W      scan: each line is held dwell+1 cycles
//  data_out  output  2**N_IN      registered one-hot output (all-zero when idle)
//  index     output  N_IN         code currently driven on data_out
//  wrap      output  1            1-cycle pulse when scan wraps from 2**N_IN-1 to 0
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, data_out=0, index=0, wrap=0, dwell counter=0.
//  States
//   IDLE   -> DIRECT on (en & load & !mode)
//   IDLE   -> SCAN   on (en & load &  mode)
//   DIRECT/SCAN -> the state selected by mode on a new (en & load)
//   any    -> IDLE   on !en
//  Timing
//   - Latency: load at edge k -> data_out = 1<<data_in and index = data_in after edge k.
//     Combinational paths from inputs to outputs are not permitted.
//  DIRECT
//   - data_out and index hold the loaded code until the next load or !en.
//  SCAN
//   - dwell is latched at load; later changes to dwell are ignored until the next load.
//   - Each index is held exactly dwell+1 cycles, then index = index+1, modulo 2**N_IN.
//   - wrap=1 in the same cycle index first shows 0 after 2**N_IN-1.
//   - wrap is 0 otherwise, including when a load starts the scan at 0.
//   - dwell=0: index advances every cycle.
//  Edge cases
//   - mode changes without load have no effect.
//   - load while en=0 is ignored.
//   - load during SCAN restarts the scan from the new data_in with the new dwell;
//     the dwell counter is cleared.
//   - !en mid-operation: the next edge gives data_out=0 and wrap=0, and the dwell
//     counter is cleared.
//     index holds its last value. Re-enabling alone does not restart: a load is required.
//   - en & load in the same cycle that en rises: the load is accepted.
//   - data_out is always either all-zero or exactly one-hot (never multi-hot).
// TESTING
//  1. N_IN=3, direct, load data_in=0..7 every 10 cycles
//     -> data_out = 00000001 .. 10000000, one cycle after each load.
//  2. Scan, data_in=0, dwell=0
//     -> data_out 00000001,00000010,...,10000000,00000001.
//     -> wrap=1 only in the cycle data_out returns to 00000001.
//  3. Scan, data_in=5, dwell=2
//     -> index 5,5,5,6,6,6,7,7,7,0(wrap),0,0,1...
//  4. Scan running at index 6, load mode=0 data_in=2 -> next cycle data_out=00000100.
//     -> the output then holds at 00000100.
//  5. Scan running, drop en for 3 cycles -> data_out=0 and wrap=0, index held.
//     -> after en=1, still 0 until a load.
//     -> async rst mid-scan clears all outputs without waiting for a clock edge.
//  6. N_IN=4, scan dwell=1 from 15
//     -> index 15,15,0(wrap),0,1,...
//     -> checker asserts data_out == (1<<index) or 0 on every cycle.

Source files
------------

// File: rtl/decoder_nx2n_scan.sv
// decoder_nx2n_scan: N-to-2^N one-hot decoder with registered output.
// Direct mode holds a loaded code; scan mode walks the one-hot output through
// every line, holding each line for dwell+1 cycles.
//
// state  | meaning
// IDLE   | outputs inactive, waiting for an enabled load
// DIRECT | holding the loaded code on data_out
// SCAN   | stepping index every dwell+1 cycles, wrapping modulo 2**N_IN
module decoder_nx2n_scan #(
    parameter int N_IN    = 3,
    parameter int DWELL_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic                 mode,
    input  logic [N_IN-1:0]      data_in,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [2**N_IN-1:0]   data_out,
    output logic [N_IN-1:0]      index,
    output logic                 wrap
);

    localparam int W = 2**N_IN;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_t;

    state_t             state;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [N_IN-1:0]    index_nxt;
    logic               dwell_done;

    function automatic logic [W-1:0] onehot(input logic [N_IN-1:0] code);
        return W'(1) << code;
    endfunction

    assign index_nxt  = index + N_IN'(1);
    assign dwell_done = (dwell_cnt == dwell_q);

    // Mode FSM, dwell timer and registered decoder outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            data_out  <= '0;
            index     <= '0;
            wrap      <= 1'b0;
            dwell_q   <= '0;
            dwell_cnt <= '0;
        end else if (!en) begin
            // index is deliberately held so software can see where it stopped
            state     <= IDLE;
            data_out  <= '0;
            wrap      <= 1'b0;
            dwell_cnt <= '0;
        end else if (load) begin
            state     <= mode ? SCAN : DIRECT;
            index     <= data_in;
            data_out  <= onehot(data_in);
            wrap      <= 1'b0;
            dwell_q   <= dwell;
            dwell_cnt <= '0;
        end else begin
            case (state)
                SCAN: begin
                    if (dwell_done) begin
                        dwell_cnt <= '0;
                        index     <= index_nxt;
                        data_out  <= onehot(index_nxt);
                        wrap      <= (index == {N_IN{1'b1}});
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                        wrap      <= 1'b0;
                    end
                end
                DIRECT: begin
                    wrap <= 1'b0;
                end
                default: begin
                    data_out <= '0;
                    wrap     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_nx2n_scan.sv
// Bench for decoder_nx2n_scan: direct-mode vector table, scan sequences,
// enable/reset corner cases, and an N_IN=4 instance for the 15->0 wrap.
module tb_decoder_nx2n_scan;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       en, load, mode;
    logic [2:0] din;
    logic [3:0] dwell;
    logic [7:0] dout;
    logic [2:0] idx;
    logic       wrap;

    logic        en4, load4, mode4;
    logic [3:0]  din4;
    logic [3:0]  dwell4;
    logic [15:0] dout4;
    logic [3:0]  idx4;
    logic        wrap4;

    decoder_nx2n_scan #(.N_IN(3), .DWELL_W(4)) dut3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .mode(mode),
        .data_in(din), .dwell(dwell), .data_out(dout), .index(idx), .wrap(wrap)
    );

    decoder_nx2n_scan #(.N_IN(4), .DWELL_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .load(load4), .mode(mode4),
        .data_in(din4), .dwell(dwell4), .data_out(dout4), .index(idx4), .wrap(wrap4)
    );

    int n_vec = 0;
    int n_mis = 0;

    typedef struct {
        logic [15:0] out;
        logic [3:0]  idx;
        logic        wrap;
    } exp_t;
    exp_t q[$];

    typedef struct {
        logic [2:0] din;
        logic [7:0] exp_out;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of the N_IN=3 instance; load is a one-cycle strobe.
    task automatic step(input string name, input logic [7:0] eo, input logic [2:0] ei, input logic ew);
        exp_t e;
        q.push_back('{out: 16'(eo), idx: 4'(ei), wrap: ew});
        @(posedge clk);
        #1;
        load = 1'b0;
        e = q.pop_front();
        check(name, {20'd0, dout, 1'b0, idx, wrap}, {20'd0, e.out[7:0], 1'b0, e.idx[2:0], e.wrap});
    endtask

    task automatic step4(input string name, input logic [15:0] eo, input logic [3:0] ei, input logic ew);
        exp_t e;
        q.push_back('{out: eo, idx: ei, wrap: ew});
        @(posedge clk);
        #1;
        load4 = 1'b0;
        e = q.pop_front();
        check(name, {11'd0, dout4, idx4, wrap4}, {11'd0, e.out, e.idx, e.wrap});
    endtask

    // Output must be all-zero or exactly the one-hot of index, every cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("onehot3", {24'd0, dout}, (dout == 8'd0) ? 32'd0 : (32'd1 << idx));
            check("onehot4", {16'd0, dout4}, (dout4 == 16'd0) ? 32'd0 : (32'd1 << idx4));
        end
    end

    initial begin
        vecs[0] = '{3'd0, 8'b00000001};
        vecs[1] = '{3'd1, 8'b00000010};
        vecs[2] = '{3'd2, 8'b00000100};
        vecs[3] = '{3'd3, 8'b00001000};
        vecs[4] = '{3'd4, 8'b00010000};
        vecs[5] = '{3'd5, 8'b00100000};
        vecs[6] = '{3'd6, 8'b01000000};
        vecs[7] = '{3'd7, 8'b10000000};

        rst = 1'b1; en = 0; load = 0; mode = 0; din = 0; dwell = 0;
        en4 = 0; load4 = 0; mode4 = 0; din4 = 0; dwell4 = 0;
        #2;
        check("reset3", {20'd0, dout, 1'b0, idx, wrap}, 32'd0);
        check("reset4", {11'd0, dout4, idx4, wrap4}, 32'd0);
        #10 rst = 1'b0;
        @(posedge clk); #1;

        // direct mode: each code decoded one cycle after load, then held
        en = 1; mode = 0;
        for (int i = 0; i < 8; i++) begin
            din = vecs[i].din; load = 1;
            step("direct_load", vecs[i].exp_out, vecs[i].din, 1'b0);
            din = 3'(7 - i); mode = 1;
            for (int h = 0; h < 3; h++) step("direct_hold", vecs[i].exp_out, vecs[i].din, 1'b0);
            mode = 0;
        end

        // scan from 0, dwell 0: wrap only when returning to line 0
        mode = 1; din = 0; dwell = 0; load = 1;
        step("scan_d0_start", 8'b00000001, 3'd0, 1'b0);
        for (int i = 1; i <= 9; i++)
            step("scan_d0", 8'(1 << (i % 8)), 3'(i % 8), (i == 8));

        // scan from 5, dwell 2; dwell input changed afterwards must be ignored
        din = 5; dwell = 2; load = 1;
        step("scan_d2_start", 8'b00100000, 3'd5, 1'b0);
        dwell = 0;
        for (int k = 1; k <= 12; k++)
            step("scan_d2", 8'(1 << ((5 + k / 3) % 8)), 3'((5 + k / 3) % 8), (k == 9));

        // scan at 6 then direct load of 2 stops and holds
        din = 4; dwell = 0; load = 1;
        step("scan_to6_a", 8'b00010000, 3'd4, 1'b0);
        step("scan_to6_b", 8'b00100000, 3'd5, 1'b0);
        step("scan_to6_c", 8'b01000000, 3'd6, 1'b0);
        mode = 0; din = 2; load = 1;
        step("scan_to_direct", 8'b00000100, 3'd2, 1'b0);
        mode = 1;
        for (int h = 0; h < 3; h++) step("direct_after_scan", 8'b00000100, 3'd2, 1'b0);

        // enable drop mid-scan: output off, index held, load ignored, no auto restart
        mode = 1; din = 0; dwell = 1; load = 1;
        step("scan_en_a", 8'b00000001, 3'd0, 1'b0);
        step("scan_en_b", 8'b00000001, 3'd0, 1'b0);
        step("scan_en_c", 8'b00000010, 3'd1, 1'b0);
        en = 0;
        step("en_off_1", 8'd0, 3'd1, 1'b0);
        din = 6; load = 1;
        step("en_off_load_ignored", 8'd0, 3'd1, 1'b0);
        step("en_off_3", 8'd0, 3'd1, 1'b0);
        en = 1;
        step("en_on_no_load_1", 8'd0, 3'd1, 1'b0);
        step("en_on_no_load_2", 8'd0, 3'd1, 1'b0);
        en = 0;
        step("en_off_again", 8'd0, 3'd1, 1'b0);
        en = 1; mode = 1; din = 7; dwell = 0; load = 1;
        step("en_rise_load", 8'b10000000, 3'd7, 1'b0);
        step("wrap_7_to_0", 8'b00000001, 3'd0, 1'b1);
        step("after_wrap", 8'b00000010, 3'd1, 1'b0);

        // async reset mid-cycle clears outputs without a clock edge
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        check("async_rst", {20'd0, dout, 1'b0, idx, wrap}, 32'd0);
        #2 rst = 1'b0;
        step("post_rst_idle", 8'd0, 3'd0, 1'b0);
        en = 0;

        // N_IN=4: scan from 15 with dwell 1
        en4 = 1; mode4 = 1; din4 = 15; dwell4 = 1; load4 = 1;
        step4("scan4_start", 16'h8000, 4'd15, 1'b0);
        for (int k = 1; k <= 7; k++)
            step4("scan4", 16'(1 << ((15 + k / 2) % 16)), 4'((15 + k / 2) % 16), (k == 2));
        en4 = 0;
        step4("scan4_off", 16'd0, 4'd2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
